// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

    // Number of instruction words in the fetch-side memory.
    localparam int unsigned ImDepth = 1024;

    // PC that corresponds to word index 0.
    localparam logic [31:0] ImBasePc = 32'h0000_3000;

    typedef enum logic [2:0] {
        StHdrHi = 3'd0,
        StHdrLo = 3'd1,
        StData  = 3'd2,
        StCsum  = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs a byte stream into big-endian 32-bit words and pulses word_valid_o
// the cycle after the fourth byte of each word is accepted.
module imem_loader_byte_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    // Next-state: shift bytes in, capture the full word on the lane-3 byte.
    always_comb begin
        shift_d = shift_q;
        lane_d  = lane_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (flush_i) begin
            shift_d = '0;
            lane_d  = '0;
            word_d  = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            lane_d  = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
                word_d  = {shift_q, byte_i};
                valid_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partially assembled word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream, writes words to the
// instruction memory and releases the CPU once the checksum is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned Depth    = ImDepth,
    parameter int unsigned MaxWords = Depth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    input  logic [7:0]               in_data_i,
    output logic                     in_ready_o,
    input  logic                     clear_i,
    output logic                     im_we_o,
    output logic [$clog2(Depth)-1:0] im_addr_o,
    output logic [31:0]              im_wdata_o,
    output logic                     cpu_reset_o,
    output logic                     done_o,
    output logic                     error_o
);

    localparam int unsigned AddrW     = $clog2(Depth);
    // One extra bit so a full-depth frame can be counted without wrapping.
    localparam int unsigned CntW      = AddrW + 1;
    localparam logic [15:0] MaxWordsW = 16'(MaxWords);

    state_e           state_q, state_d;
    logic [15:0]      count_q, count_d;
    logic [CntW-1:0]  wcnt_q, wcnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [AddrW-1:0] addr_q, addr_d;

    logic        take;
    logic [15:0] hdr;
    logic        pk_valid, pk_flush, pk_word_valid;
    logic [1:0]  pk_lane;
    logic [31:0] pk_word;

    assign in_ready_o = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign take       = in_valid_i && in_ready_o;
    assign hdr        = {count_q[15:8], in_data_i};

    // Frame FSM next-state, counters and checksum accumulator.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wcnt_d   = wcnt_q;
        csum_d   = csum_q;
        addr_d   = addr_q;
        pk_valid = 1'b0;
        pk_flush = 1'b0;
        unique case (state_q)
            StHdrHi: begin
                if (take) begin
                    count_d[15:8] = in_data_i;
                    state_d       = StHdrLo;
                end
            end
            StHdrLo: begin
                if (take) begin
                    count_d[7:0] = in_data_i;
                    if (hdr == 16'd0 || hdr > MaxWordsW) begin
                        state_d = StErr;
                    end else begin
                        state_d  = StData;
                        wcnt_d   = '0;
                        csum_d   = '0;
                        pk_flush = 1'b1;
                    end
                end
            end
            StData: begin
                if (take) begin
                    pk_valid = 1'b1;
                    csum_d   = csum_q ^ in_data_i;
                    if (pk_lane == 2'd3) begin
                        addr_d = wcnt_q[AddrW-1:0];
                        wcnt_d = wcnt_q + 1'b1;
                        if (16'(wcnt_q) + 16'd1 == count_q) begin
                            state_d = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (take) begin
                    state_d = (in_data_i == csum_q) ? StDone : StErr;
                end
            end
            StDone, StErr: begin
                if (clear_i) begin
                    state_d  = StHdrHi;
                    count_d  = '0;
                    wcnt_d   = '0;
                    csum_d   = '0;
                    pk_flush = 1'b1;
                end
            end
            default: state_d = StHdrHi;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StHdrHi;
            count_q <= '0;
            wcnt_q  <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
        end
    end

    imem_loader_byte_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (pk_flush),
        .byte_valid_i (pk_valid),
        .byte_i       (in_data_i),
        .lane_o       (pk_lane),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    assign im_we_o     = pk_word_valid;
    assign im_addr_o   = addr_q;
    assign im_wdata_o  = pk_word;
    assign done_o      = (state_q == StDone);
    assign error_o     = (state_q == StErr);
    assign cpu_reset_o = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frame table, randomized
// frames against a frame-level reference model, and reset/clear corners.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        clear = 1'b0;
    logic        in_ready, im_we, cpu_reset, done, error;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;

    int checks = 0;
    int errors = 0;

    bit [31:0] fw [1024];
    bit [9:0]  wr_addr_q [$];
    bit [31:0] wr_data_q [$];

    typedef struct {
        bit [15:0] hdr;
        bit [31:0] w0;
        bit [31:0] w1;
        bit [7:0]  csum;
        bit        body;
        bit        toggle;
        bit        exp_done;
        int        exp_writes;
    } vec_t;

    vec_t tbl [5];

    imem_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .clear_i     (clear),
        .im_we_o     (im_we),
        .im_addr_o   (im_addr),
        .im_wdata_o  (im_wdata),
        .cpu_reset_o (cpu_reset),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (im_we !== 1'b0) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: XOR of all data bytes of the first n words.
    function automatic bit [7:0] model_csum(input int n);
        bit [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            for (int l = 0; l < 4; l++) x ^= fw[i][8*l +: 8];
        return x;
    endfunction

    function automatic bit model_hdr_ok(input bit [15:0] h);
        return (h != 16'd0) && (h <= 16'd1024);
    endfunction

    // Drive one frame (header, optional body+checksum) starting at a negedge.
    task automatic run_frame(input string name, input bit [15:0] hdr, input bit body,
                             input bit [7:0] csum, input bit toggle, input bit exp_done,
                             input int exp_writes, input bit do_clear);
        int nbytes;
        bit [7:0] b;
        bit [31:0] w;
        int di;
        wr_addr_q.delete();
        wr_data_q.delete();
        nbytes = body ? 2 + 4 * int'(hdr) + 1 : 2;
        for (int i = 0; i < nbytes; i++) begin
            di = i - 2;
            if (i == 0) b = hdr[15:8];
            else if (i == 1) b = hdr[7:0];
            else if (body && i == nbytes - 1) b = csum;
            else begin
                w = fw[di / 4];
                b = w[8*(3 - di % 4) +: 8];
            end
            if (toggle) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            chk({name, " in_ready"}, in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            if (body && i >= 2 && i < nbytes - 1 && di % 4 == 3) begin
                chk({name, " im_we"}, im_we, 1'b1);
                chk({name, " im_addr"}, im_addr, 32'(di / 4));
                chk({name, " im_wdata"}, im_wdata, fw[di / 4]);
            end else begin
                chk({name, " im_we idle"}, im_we, 1'b0);
            end
        end
        in_valid = 1'b0;
        // Status must be visible from the first cycle after the last byte.
        chk({name, " done"}, done, exp_done);
        chk({name, " error"}, error, !exp_done);
        @(negedge clk);
        chk({name, " cpu_reset"}, cpu_reset, !exp_done);
        chk({name, " in_ready end"}, in_ready, 1'b0);
        chk({name, " write count"}, wr_addr_q.size(), exp_writes);
        if (wr_addr_q.size() == exp_writes) begin
            for (int k = 0; k < exp_writes; k++) begin
                chk({name, " mon addr"}, wr_addr_q[k], 32'(k));
                chk({name, " mon data"}, wr_data_q[k], fw[k]);
            end
        end
        if (do_clear) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            chk({name, " clear ready"}, in_ready, 1'b1);
            chk({name, " clear done"}, done, 1'b0);
            chk({name, " clear error"}, error, 1'b0);
            chk({name, " clear cpu_reset"}, cpu_reset, 1'b1);
        end
    endtask

    initial begin
        bit [15:0] h;
        bit [7:0]  cs;
        bit        ok;
        int        r;

        tbl[0] = '{16'd1, 32'h2401_0005, 32'h0, 8'h20, 1'b1, 1'b0, 1'b1, 1};
        tbl[1] = '{16'd2, 32'h3C01_1234, 32'h0, 8'h1B, 1'b1, 1'b1, 1'b1, 2};
        tbl[2] = '{16'd1, 32'h2401_0005, 32'h0, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
        tbl[3] = '{16'h0000, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{16'h0401, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 0};

        // Values held while in reset and just after release.
        repeat (2) @(negedge clk);
        chk("rst im_we", im_we, 1'b0);
        chk("rst im_addr", im_addr, 10'd0);
        chk("rst im_wdata", im_wdata, 32'd0);
        chk("rst done", done, 1'b0);
        chk("rst error", error, 1'b0);
        chk("rst cpu_reset", cpu_reset, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", in_ready, 1'b1);
        chk("post-rst cpu_reset", cpu_reset, 1'b1);

        // Directed frame table.
        for (int t = 0; t < 5; t++) begin
            fw[0] = tbl[t].w0;
            fw[1] = tbl[t].w1;
            run_frame($sformatf("tbl%0d", t), tbl[t].hdr, tbl[t].body, tbl[t].csum,
                      tbl[t].toggle, tbl[t].exp_done, tbl[t].exp_writes, 1'b1);
        end

        // Randomized frames checked against the frame-level model.
        for (int f = 0; f < 12; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) h = 16'h0000;
            else if (r == 1) h = 16'($urandom_range(1025, 65535));
            else h = 16'($urandom_range(1, 6));
            ok = model_hdr_ok(h);
            if (ok) for (int i = 0; i < int'(h); i++) fw[i] = $urandom;
            cs = ok ? model_csum(int'(h)) : 8'h00;
            if (ok && $urandom_range(0, 3) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            run_frame($sformatf("rnd%0d", f), h, ok, cs, 1'($urandom_range(0, 1)),
                      ok && (cs == model_csum(int'(h))), ok ? int'(h) : 0, 1'b1);
        end

        // Full-depth frame: last write lands at index 1023.
        for (int i = 0; i < 1024; i++) fw[i] = $urandom;
        run_frame("full", 16'd1024, 1'b1, model_csum(1024), 1'b0, 1'b1, 1024, 1'b1);

        // Reset mid-frame after two data bytes: no stray write.
        in_valid = 1'b1;
        in_data  = 8'h00; @(negedge clk);
        in_data  = 8'h01; @(negedge clk);
        in_data  = 8'hAB; @(negedge clk);
        in_data  = 8'hCD; @(negedge clk);
        in_valid = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst in_ready", in_ready, 1'b1);
        chk("midrst cpu_reset", cpu_reset, 1'b1);
        chk("midrst im_wdata", im_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst no write", wr_addr_q.size(), 0);
        fw[0] = 32'h1122_3344;
        run_frame("after-rst", 16'd1, 1'b1, model_csum(1), 1'b0, 1'b1, 1, 1'b0);

        // Clear together with a byte in DONE: clear wins, byte is dropped.
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        chk("clr+valid in_ready", in_ready, 1'b0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr+valid hdr_hi ready", in_ready, 1'b1);
        chk("clr+valid done", done, 1'b0);
        chk("clr+valid cpu_reset", cpu_reset, 1'b1);
        fw[0] = 32'hA5A5_0F0F;
        run_frame("post-clr", 16'd1, 1'b1, model_csum(1), 1'b0, 1'b1, 1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 1024-word instruction memory that the fetch stage reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to sequential word addresses starting at 0; word index 0 corresponds to PC 0x0000_3000.
- Holds the CPU in reset until a complete frame with a correct checksum has been written.

Parameters:
- DEPTH, 1024, number of instruction words; im_addr width is clog2(DEPTH).
- MAX_WORDS, DEPTH, largest word count accepted in a frame header.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- clear  in  1  synchronous restart request, honoured only in DONE or ERR.
- im_we  out  1  instruction-memory write strobe, one cycle wide.
- im_addr  out  10  word index being written.
- im_wdata  out  32  word being written.
- cpu_reset  out  1  active-high reset to the CPU core.
- done  out  1  frame loaded and checksum correct.
- error  out  1  frame rejected.

Behaviour:
- Frame format, in order:
  - Header: count[15:8], then count[7:0].
  - Data: count*4 bytes, big-endian per word (first byte goes to wdata[31:24]).
  - Trailer: 1 checksum byte, equal to the XOR of all data bytes (header excluded).
- Handshake:
  - A byte transfers on a rising edge where in_valid && in_ready.
  - in_data must be held while in_valid=1 && in_ready=0.
- States: HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- In-reset and post-reset values:
  - State HDR_HI; all counters and the checksum accumulator zero.
  - im_we=0, im_addr=0, im_wdata=0, done=0, error=0, cpu_reset=1.
- in_ready: 1 in HDR_HI, HDR_LO, DATA and CSUM; 0 in DONE and ERR. The loader never back-pressures mid-frame.
- HDR_HI: on transfer, latch count[15:8] and go to HDR_LO.
- HDR_LO: on transfer, latch count[7:0], then:
  - count==0 or count>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA; word counter=0, byte lane=0, checksum=0.
- DATA, on each transfer:
  - Shift the byte into the assembly register and XOR it into the checksum.
  - Increment the byte lane (2-bit, wraps modulo 4).
- Write timing on the lane-3 transfer:
  - Next cycle: im_we=1, im_wdata=assembled word, im_addr=word counter.
  - The word counter then increments.
  - Write latency is one cycle after the 4th byte's accepting edge.
  - A new byte may be accepted in the same cycle im_we is high.
- Leaving DATA: after the lane-3 transfer of word count-1, go to CSUM.
- CSUM: on transfer, compare the byte with the accumulator.
  - Equal: go to DONE.
  - Not equal: go to ERR.
- DONE: done=1, cpu_reset=0 from the first cycle in DONE.
- ERR: error=1, cpu_reset=1. Memory contents already written are left unchanged.
- clear:
  - In DONE or ERR: next state HDR_HI; done, error and counters cleared; cpu_reset=1.
  - In any other state: ignored.
- Simultaneous clear and in_valid in DONE or ERR: clear wins; the byte is not accepted (in_ready=0).
- Address arithmetic:
  - The word counter is 11 bits, so count==1024 is reachable.
  - im_addr takes the low 10 bits; index 1023 is the last write, with no wrap.
- Reset asserted mid-frame: immediate return to the reset values; the partial word is discarded; no im_we pulse.

Decomposition:
- Shared package holds:
  - The state encoding: HDR_HI=0, HDR_LO=1, DATA=2, CSUM=3, DONE=4, ERR=5.
  - IM_BASE_PC=32'h0000_3000.
  - The DEPTH default.
- One natural sub-module: byte_word_packer (shift register, lane counter, word-ready pulse). The FSM and checksum stay in imem_loader.

Test Plan:
- Count=1, bytes 24 01 00 05, checksum 0x20 -> im_we one cycle after the 4th byte, im_addr=0, im_wdata=0x24010005; then done=1, cpu_reset=0.
- Count=2 with words 0x3C011234, 0x00000000 sent with in_valid toggling every other cycle -> writes at addr 0 then 1 with the correct data; checksum 0x3C^0x01^0x12^0x34 = 0x1B gives done=1.
- Count=1 with a correct payload but checksum 0xFF -> im_we fires once, then error=1, cpu_reset stays 1, in_ready=0.
- Header 0x0000, then header 0x0401 (1025 words) after clear -> error=1 immediately after the 2nd header byte, with no im_we in either case.
- Count=1024 -> last write at im_addr=1023 with no wrap; done=1 after the correct checksum.
- Mid-frame reset=0 after 2 data bytes, then a fresh count=1 frame -> no stray write; the fresh word lands at addr 0; assert clear+in_valid in DONE and check the byte is not accepted and the state returns to HDR_HI.
